// File: rtl/pmod_axi_bridge.sv
// 2-bit PMOD serial slave bridged to single-beat 64-bit AXI4 reads/writes.
// Host frames carry length, address and optional write data; reads return over prd.
module pmod_axi_bridge (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [63:0] M_AXI_RDATA,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  input  logic        pck,
  input  logic        pwrite,
  input  logic [1:0]  pwd,
  output logic [1:0]  prd,
  output logic        pwait
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_WDAT = 3'd1;
  localparam logic [2:0] S_AXW  = 3'd2;
  localparam logic [2:0] S_AXR  = 3'd3;
  localparam logic [2:0] S_RDAT = 3'd4;

  logic       pck_s1_q, pck_s2_q, pck_p_q;
  logic       pwr_s1_q, pwr_s2_q;
  logic [1:0] pwd_s1_q, pwd_s2_q;

  logic [2:0]  state_q, state_d;
  logic [5:0]  sym_q, sym_d;
  logic        wr_q, wr_d;
  logic [9:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic        got_q, got_d;
  logic        pwait_q, pwait_d;
  logic        awv_q, awv_d;
  logic        wv_q, wv_d;
  logic        arv_q, arv_d;
  logic        rrdy_q, rrdy_d;
  logic [31:0] axaddr_q, axaddr_d;
  logic [2:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;

  logic       rise_w, fall_w;
  logic [3:0] l_w;
  logic [5:0] nsym_w;
  logic [2:0] size_w;
  logic [8:0] lmask_w;
  logic       unused_ok;

  assign rise_w  = pck_s2_q & ~pck_p_q;
  assign fall_w  = ~pck_s2_q & pck_p_q;
  assign l_w     = (len_q == 10'd0) ? 4'd1 :
                   (len_q > 10'd8)  ? 4'd8 : len_q[3:0];
  assign nsym_w  = {l_w, 2'b00};
  assign size_w  = (l_w == 4'd1) ? 3'd0 :
                   (l_w == 4'd2) ? 3'd1 :
                   (l_w <= 4'd4) ? 3'd2 : 3'd3;
  assign lmask_w = (9'd1 << l_w) - 9'd1;
  assign unused_ok = ^{M_AXI_BVALID, M_AXI_RLAST};

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    wr_d     = wr_q;
    len_d    = len_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rbuf_d   = rbuf_q;
    got_d    = got_q;
    pwait_d  = pwait_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    arv_d    = arv_q;
    rrdy_d   = rrdy_q;
    axaddr_d = axaddr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    unique case (state_q)
      S_HDR: if (fall_w) begin
        sym_d = sym_q + 6'd1;
        if (sym_q == 6'd0) wr_d = pwr_s2_q;
        if (sym_q < 6'd5) len_d = {pwd_s2_q, len_q[9:2]};
        else addr_d = {pwd_s2_q, addr_q[31:2]};
        if (sym_q == 6'd20) begin
          sym_d  = 6'd0;
          data_d = '0;
          size_d = size_w;
          if (wr_q) begin
            state_d = S_WDAT;
          end else begin
            state_d  = S_AXR;
            axaddr_d = addr_d;
            arv_d    = 1'b1;
            rrdy_d   = 1'b1;
            got_d    = 1'b0;
            pwait_d  = 1'b1;
          end
        end
      end
      S_WDAT: if (fall_w) begin
        data_d[{sym_q[4:0], 1'b0} +: 2] = pwd_s2_q;
        sym_d = sym_q + 6'd1;
        if (sym_q == nsym_w - 6'd1) begin
          state_d  = S_AXW;
          sym_d    = 6'd0;
          pwait_d  = 1'b1;
          awv_d    = 1'b1;
          wv_d     = 1'b1;
          axaddr_d = addr_q;
          // byte i lands on lane addr[2:0]+i; lanes past 7 fall off
          wdata_d  = data_d << {addr_q[2:0], 3'b000};
          wstrb_d  = lmask_w[7:0] << addr_q[2:0];
        end
      end
      S_AXW: begin
        if (M_AXI_AWREADY) awv_d = 1'b0;
        if (M_AXI_WREADY) wv_d = 1'b0;
        if ((!awv_q || M_AXI_AWREADY) && (!wv_q || M_AXI_WREADY)) begin
          state_d = S_HDR;
          pwait_d = 1'b0;
        end
      end
      S_AXR: begin
        if (M_AXI_ARREADY) arv_d = 1'b0;
        if (rrdy_q && M_AXI_RVALID && !got_q) begin
          rbuf_d = M_AXI_RDATA >> {addr_q[2:0], 3'b000};
          got_d  = 1'b1;
        end
        if (got_q && rise_w) begin
          state_d = S_RDAT;
          pwait_d = 1'b0;
          rrdy_d  = 1'b0;
          sym_d   = 6'd0;
        end
      end
      S_RDAT: if (rise_w) begin
        rbuf_d = rbuf_q >> 2;
        sym_d  = sym_q + 6'd1;
        if (sym_q == nsym_w - 6'd1) begin
          state_d = S_HDR;
          sym_d   = 6'd0;
          rbuf_d  = '0;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      pck_s1_q <= 1'b0;
      pck_s2_q <= 1'b0;
      pck_p_q  <= 1'b0;
      pwr_s1_q <= 1'b0;
      pwr_s2_q <= 1'b0;
      pwd_s1_q <= 2'd0;
      pwd_s2_q <= 2'd0;
      state_q  <= S_HDR;
      sym_q    <= 6'd0;
      wr_q     <= 1'b0;
      len_q    <= 10'd0;
      addr_q   <= 32'd0;
      data_q   <= 64'd0;
      rbuf_q   <= 64'd0;
      got_q    <= 1'b0;
      pwait_q  <= 1'b0;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      arv_q    <= 1'b0;
      rrdy_q   <= 1'b0;
      axaddr_q <= 32'd0;
      size_q   <= 3'd0;
      wdata_q  <= 64'd0;
      wstrb_q  <= 8'd0;
    end else begin
      pck_s1_q <= pck;
      pck_s2_q <= pck_s1_q;
      pck_p_q  <= pck_s2_q;
      pwr_s1_q <= pwrite;
      pwr_s2_q <= pwr_s1_q;
      pwd_s1_q <= pwd;
      pwd_s2_q <= pwd_s1_q;
      state_q  <= state_d;
      sym_q    <= sym_d;
      wr_q     <= wr_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rbuf_q   <= rbuf_d;
      got_q    <= got_d;
      pwait_q  <= pwait_d;
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      arv_q    <= arv_d;
      rrdy_q   <= rrdy_d;
      axaddr_q <= axaddr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign M_AXI_AWADDR  = axaddr_q;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = size_q;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awv_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = wv_q;
  assign M_AXI_BREADY  = 1'b1;
  assign M_AXI_ARADDR  = axaddr_q;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = size_q;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arv_q;
  assign M_AXI_RREADY  = rrdy_q;
  assign prd           = rbuf_q[1:0];
  assign pwait         = pwait_q;

endmodule

// File: tb/tb_pmod_axi_bridge.sv
// Bench for pmod_axi_bridge: host frame driver, AXI slave responder,
// and a byte-lane reference model for writes and read-back symbols.
`timescale 1ns/1ps
module tb_pmod_axi_bridge;

  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic [63:0] wdata, rdata;
  logic        rlast, rvalid, rready;
  logic        pck, pwrite, pwait;
  logic [1:0]  pwd, prd;

  int n_cmp = 0;
  int n_bad = 0;

  int aw_dly, w_dly, ar_dly, r_dly;
  logic [63:0] rd_val;
  int aw_cnt, w_cnt, ar_cnt, r_cnt;
  bit r_pend;

  logic [31:0] awa_q[$];
  logic [2:0]  aws_q[$];
  logic [12:0] awx_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  logic        wl_q[$];
  logic [31:0] ara_q[$];
  logic [2:0]  ars_q[$];

  pmod_axi_bridge dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready),
    .pck(pck), .pwrite(pwrite), .pwd(pwd), .prd(prd), .pwait(pwait)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

  // AXI slave responder: READY after a programmable number of VALID cycles
  initial begin
    awready = 0; wready = 0; arready = 0; rvalid = 0;
    rdata = '0; rlast = 1; bvalid = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; r_pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; r_pend = 0;
      end else begin
        if (r_pend) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1; rdata = rd_val;
            if (rready) r_pend = 0;
          end else begin
            r_cnt++; rvalid = 0;
          end
        end else rvalid = 0;
        if (awvalid) begin
          awready = (aw_cnt >= aw_dly);
          if (awready) begin
            awa_q.push_back(awaddr); aws_q.push_back(awsize);
            awx_q.push_back({awlen, awburst, awprot});
            aw_cnt = 0;
          end else aw_cnt++;
        end else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin
          wready = (w_cnt >= w_dly);
          if (wready) begin
            wd_q.push_back(wdata); ws_q.push_back(wstrb);
            wl_q.push_back(wlast); w_cnt = 0;
          end else w_cnt++;
        end else begin wready = 0; w_cnt = 0; end
        if (arvalid) begin
          arready = (ar_cnt >= ar_dly);
          if (arready) begin
            ara_q.push_back(araddr); ars_q.push_back(arsize);
            ar_cnt = 0; r_pend = 1; r_cnt = 0;
          end else ar_cnt++;
        end else begin arready = 0; ar_cnt = 0; end
      end
    end
  end

  function automatic int eff_len(input int len);
    return (len == 0) ? 1 : (len > 8) ? 8 : len;
  endfunction

  function automatic logic [2:0] exp_size(input int len);
    int l = eff_len(len);
    if (l == 1) return 3'd0;
    if (l == 2) return 3'd1;
    if (l <= 4) return 3'd2;
    return 3'd3;
  endfunction

  function automatic void exp_write(input int len, input logic [31:0] a,
      input logic [63:0] d, output logic [63:0] ed, output logic [7:0] es);
    int ln;
    ed = '0; es = '0;
    for (int i = 0; i < eff_len(len); i++) begin
      ln = int'(a[2:0]) + i;
      if (ln < 8) begin es[ln] = 1'b1; ed[8*ln +: 8] = d[8*i +: 8]; end
    end
  endfunction

  // bytes the host should see, packed so symbol j sits at bits [2j+1:2j]
  function automatic logic [63:0] exp_read(input int len,
      input logic [31:0] a, input logic [63:0] rd);
    logic [63:0] ev = '0;
    int ln;
    for (int i = 0; i < eff_len(len); i++) begin
      ln = int'(a[2:0]) + i;
      if (ln < 8) ev[8*i +: 8] = rd[8*ln +: 8];
    end
    return ev;
  endfunction

  task automatic clear_logs();
    awa_q.delete(); aws_q.delete(); awx_q.delete();
    wd_q.delete(); ws_q.delete(); wl_q.delete();
    ara_q.delete(); ars_q.delete();
  endtask

  task automatic send_sym(input logic [1:0] s);
    pck = 1; pwd = s;
    repeat (HP) @(negedge clk);
    pck = 0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic send_frame(input bit wr, input int len,
      input logic [31:0] a, input logic [63:0] d);
    logic [9:0] l10 = 10'(len);
    pwrite = wr;
    for (int i = 0; i < 5; i++) send_sym(l10[2*i +: 2]);
    for (int i = 0; i < 16; i++) send_sym(a[2*i +: 2]);
    if (wr)
      for (int i = 0; i < 4 * eff_len(len); i++) send_sym(d[2*i +: 2]);
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    repeat (3) @(negedge clk);
    while (pwait && t < 300) begin @(negedge clk); t++; end
    ok = !pwait;
  endtask

  task automatic run_read(input int len, input logic [31:0] a,
      output logic [63:0] syms, output bit pw_before, output bit aligned);
    int k = 0;
    syms = '0; aligned = 0; pw_before = 0;
    send_frame(1'b0, len, a, '0);
    while (!aligned && k < 60) begin
      repeat (HP) @(negedge clk);
      pw_before = pwait;
      pck = 1;
      repeat (HP) @(negedge clk);
      if (!pwait) aligned = 1;
      else pck = 0;
      k++;
    end
    if (aligned)
      for (int j = 0; j < 4 * eff_len(len); j++) begin
        syms[2*j +: 2] = prd;
        pck = 0;
        repeat (HP) @(negedge clk);
        pck = 1;
        repeat (HP) @(negedge clk);
      end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, arvalid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_valids got %b want 000", {awvalid, wvalid, arvalid});
    end
    n_cmp++;
    if ({pwait, prd, bready, rready} !== 5'b00010) begin
      n_bad++; $display("FAIL reset_ctl got %b want 00010", {pwait, prd, bready, rready});
    end
    n_cmp++;
    if ({awaddr, araddr, wdata} !== 128'd0) begin
      n_bad++; $display("FAIL reset_payload got %h want 0", {awaddr, araddr, wdata});
    end
    rst_n = 1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, arvalid, pwait, bready} !== 5'b00001) begin
      n_bad++; $display("FAIL post_reset got %b want 00001",
                        {awvalid, wvalid, arvalid, pwait, bready});
    end
  endtask

  task automatic test_read();
    logic [63:0] syms, ev;
    bit pwb, al;
    clear_logs();
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 1;
    rd_val = 64'h0123_4567_dead_beef;
    run_read(4, 32'h4000_0000, syms, pwb, al);
    ev = exp_read(4, 32'h4000_0000, rd_val);
    n_cmp++;
    if (!al || !pwb) begin
      n_bad++; $display("FAIL read_align got aligned=%0d pwait_before=%0d want 1 1", al, pwb);
    end
    n_cmp++;
    if (syms !== ev) begin
      n_bad++; $display("FAIL read_syms got %h want %h", syms, ev);
    end
    n_cmp++;
    if (ara_q.size() != 1 || ara_q[0] !== 32'h4000_0000 || ars_q[0] !== 3'd2) begin
      n_bad++; $display("FAIL read_ar got n=%0d addr=%h size=%0d want 1 40000000 2",
                        ara_q.size(), (ara_q.size() > 0) ? ara_q[0] : 32'hx,
                        (ars_q.size() > 0) ? ars_q[0] : 3'hx);
    end
  endtask

  task automatic test_write();
    logic [63:0] ed;
    logic [7:0] es;
    bit ok;
    clear_logs();
    aw_dly = 0; w_dly = 0;
    send_frame(1'b1, 2, 32'h4060_0004, 64'h0068);
    wait_idle(ok);
    exp_write(2, 32'h4060_0004, 64'h0068, ed, es);
    n_cmp++;
    if (!ok || awa_q.size() != 1 || wd_q.size() != 1) begin
      n_bad++; $display("FAIL write_count got aw=%0d w=%0d idle=%0d want 1 1 1",
                        awa_q.size(), wd_q.size(), ok);
    end else begin
      n_cmp++;
      if (awa_q[0] !== 32'h4060_0004 || aws_q[0] !== 3'd1 || awx_q[0] !== 13'h008) begin
        n_bad++; $display("FAIL write_aw got %h size %0d attr %h want 40600004 1 008",
                          awa_q[0], aws_q[0], awx_q[0]);
      end
      n_cmp++;
      if (ws_q[0] !== es || wd_q[0] !== ed || wl_q[0] !== 1'b1) begin
        n_bad++; $display("FAIL write_w got strb %h data %h last %0d want %h %h 1",
                          ws_q[0], wd_q[0], wl_q[0], es, ed);
      end
    end
  endtask

  task automatic test_back_to_back();
    string msg = "hello, world\r\n";
    int bad = 0;
    bit ok;
    clear_logs();
    for (int i = 0; i < msg.len(); i++) begin
      send_frame(1'b1, 1, 32'h4060_0004, {56'd0, msg[i]});
      wait_idle(ok);
      if (!ok) bad++;
    end
    n_cmp++;
    if (bad != 0 || wd_q.size() != msg.len() || awa_q.size() != msg.len()) begin
      n_bad++; $display("FAIL b2b_count got w=%0d aw=%0d stuck=%0d want %0d",
                        wd_q.size(), awa_q.size(), bad, msg.len());
    end else begin
      bad = 0;
      for (int i = 0; i < msg.len(); i++)
        if (wd_q[i][39:32] !== msg[i] || ws_q[i] !== 8'h10) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++; $display("FAIL b2b_data got %0d wrong bytes want 0", bad);
      end
    end
  endtask

  task automatic test_stall();
    int aw_hi = 0, w_hi = 0, pw_hi = 0, unstable = 0;
    bit done = 0;
    clear_logs();
    aw_dly = 3; w_dly = 5;
    fork
      begin
        send_frame(1'b1, 2, 32'h1000_0010, 64'hbeef);
        repeat (20) @(negedge clk);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (awvalid) begin
            aw_hi++;
            if (awaddr !== 32'h1000_0010) unstable++;
          end
          if (wvalid) begin
            w_hi++;
            if (wdata !== 64'hbeef || wstrb !== 8'h03) unstable++;
          end
          if (pwait) pw_hi++;
        end
      end
    join
    aw_dly = 0; w_dly = 0;
    n_cmp++;
    if (aw_hi != 4 || w_hi != 6) begin
      n_bad++; $display("FAIL stall_valid got aw=%0d w=%0d cycles want 4 6", aw_hi, w_hi);
    end
    n_cmp++;
    if (pw_hi != 6) begin
      n_bad++; $display("FAIL stall_pwait got %0d cycles want 6", pw_hi);
    end
    n_cmp++;
    if (unstable != 0 || awa_q.size() != 1 || wd_q.size() != 1) begin
      n_bad++; $display("FAIL stall_payload got unstable=%0d aw=%0d w=%0d want 0 1 1",
                        unstable, awa_q.size(), wd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] syms, ev;
    bit pwb, al;
    pwrite = 0;
    for (int i = 0; i < 10; i++) send_sym(2'($urandom_range(0, 3)));
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    clear_logs();
    r_dly = 2;
    rd_val = {$urandom, $urandom};
    run_read(3, 32'h1000_0003, syms, pwb, al);
    ev = exp_read(3, 32'h1000_0003, rd_val);
    n_cmp++;
    if (!al || syms !== ev || ara_q.size() != 1) begin
      n_bad++; $display("FAIL reset_mid got al=%0d syms=%h n_ar=%0d want 1 %h 1",
                        al, syms, ara_q.size(), ev);
    end
  endtask

  task automatic test_random();
    logic [63:0] d, ed, syms;
    logic [31:0] a;
    logic [7:0] es;
    int len;
    bit wr, ok, pwb, al;
    for (int n = 0; n < 16; n++) begin
      clear_logs();
      wr = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 12);
      a = $urandom;
      d = {$urandom, $urandom};
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      rd_val = {$urandom, $urandom};
      if (wr) begin
        send_frame(1'b1, len, a, d);
        wait_idle(ok);
        exp_write(len, a, d, ed, es);
        n_cmp++;
        if (!ok || awa_q.size() != 1 || wd_q.size() != 1) begin
          n_bad++; $display("FAIL rnd_wr_count[%0d] got aw=%0d w=%0d want 1 1",
                            n, awa_q.size(), wd_q.size());
        end else if (awa_q[0] !== a || aws_q[0] !== exp_size(len) ||
                     ws_q[0] !== es || wd_q[0] !== ed) begin
          n_bad++; $display("FAIL rnd_wr[%0d] got %h/%0d/%h/%h want %h/%0d/%h/%h", n,
                            awa_q[0], aws_q[0], ws_q[0], wd_q[0], a, exp_size(len), es, ed);
        end
      end else begin
        run_read(len, a, syms, pwb, al);
        ev_chk: begin
          logic [63:0] ev = exp_read(len, a, rd_val);
          n_cmp++;
          if (!al || syms !== ev || ara_q.size() != 1 || ara_q[0] !== a ||
              ars_q[0] !== exp_size(len)) begin
            n_bad++; $display("FAIL rnd_rd[%0d] got al=%0d syms=%h n_ar=%0d want 1 %h 1",
                              n, al, syms, ara_q.size(), ev);
          end
        end
      end
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  initial begin
    rst_n = 0; pck = 0; pwrite = 0; pwd = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; rd_val = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
